// File: rtl/pixel_frame_sink.sv
// Sensor-side frame sink: stores one IMAGE_SIZE-pixel frame, keeps a 16-bit checksum, registered readback port.
// Define SINK_STATS_EN to build per-frame min/max tracking; otherwise pix_min/pix_max are constants.
module pixel_frame_sink #(
  parameter int IMAGE_SIZE = 1024,
  localparam int ADDR_W = $clog2(IMAGE_SIZE)
) (
  input  logic              sensor_clk,
  input  logic              rst_n,
  input  logic [7:0]        pixel,
  input  logic              valid,
  output logic              ready,
  input  logic              enable,
  input  logic              hold,
  input  logic              frame_ack,
  output logic              frame_done,
  output logic [ADDR_W:0]   pix_count,
  output logic [7:0]        frame_count,
  output logic [15:0]       checksum,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        pix_min,
  output logic [7:0]        pix_max
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMAGE_SIZE - 1);

  state_t     state_q, state_d;
  logic       xfer;
  logic       start;
  logic       last_accept;
  logic [7:0] mem [IMAGE_SIZE];

  assign ready      = (state_q == CAPTURE) && !hold;
  assign xfer       = valid && ready;
  assign frame_done = (state_q == DONE);

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Completing the frame takes priority over an abort on the same edge.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    last_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = CAPTURE;
          start   = 1'b1;
        end
      end
      CAPTURE: begin
        if (xfer && (pix_count == LAST_IDX)) begin
          state_d     = DONE;
          last_accept = 1'b1;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (frame_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count   <= '0;
      checksum    <= '0;
      frame_count <= '0;
    end else begin
      if (start) begin
        pix_count <= '0;
        checksum  <= '0;
      end else if (xfer) begin
        pix_count <= pix_count + 1'b1;
        checksum  <= checksum + {8'h00, pixel};
      end
      if (last_accept) frame_count <= frame_count + 1'b1;
    end
  end

  // Buffer has no reset; pix_count stays below IMAGE_SIZE whenever xfer is high.
  always_ff @(posedge sensor_clk) begin
    if (xfer) mem[pix_count[ADDR_W-1:0]] <= pixel;
  end

  generate
    if (IMAGE_SIZE == (1 << ADDR_W)) begin : g_rd_full
      always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
      end
    end else begin : g_rd_part
      always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n)                                           rd_data <= '0;
        else if ({1'b0, rd_addr} < (ADDR_W+1)'(IMAGE_SIZE))   rd_data <= mem[rd_addr];
        else                                                  rd_data <= '0;
      end
    end
  endgenerate

`ifdef SINK_STATS_EN
  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_min <= '1;
      pix_max <= '0;
    end else if (start) begin
      pix_min <= '1;
      pix_max <= '0;
    end else if (xfer) begin
      if (pixel < pix_min) pix_min <= pixel;
      if (pixel > pix_max) pix_max <= pixel;
    end
  end
`else
  assign pix_min = 8'hFF;
  assign pix_max = 8'h00;
`endif

endmodule

// File: tb/tb_pixel_frame_sink.sv
// Directed/randomized bench for pixel_frame_sink (IMAGE_SIZE=16) against a frame-level reference model.
module tb_pixel_frame_sink;

  localparam int N  = 16;
  localparam int AW = $clog2(N);
  localparam int P_IDLE = 0, P_CAP = 1, P_DONE = 2;

  logic          sensor_clk = 1'b0;
  logic          rst_n      = 1'b0;
  logic [7:0]    pixel      = '0;
  logic          valid      = 1'b0;
  logic          ready;
  logic          enable     = 1'b0;
  logic          hold       = 1'b0;
  logic          frame_ack  = 1'b0;
  logic          frame_done;
  logic [AW:0]   pix_count;
  logic [7:0]    frame_count;
  logic [15:0]   checksum;
  logic [AW-1:0] rd_addr    = '0;
  logic [7:0]    rd_data;
  logic [7:0]    pix_min;
  logic [7:0]    pix_max;

  pixel_frame_sink #(.IMAGE_SIZE(N)) dut (
    .sensor_clk (sensor_clk),
    .rst_n      (rst_n),
    .pixel      (pixel),
    .valid      (valid),
    .ready      (ready),
    .enable     (enable),
    .hold       (hold),
    .frame_ack  (frame_ack),
    .frame_done (frame_done),
    .pix_count  (pix_count),
    .frame_count(frame_count),
    .checksum   (checksum),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pix_min    (pix_min),
    .pix_max    (pix_max)
  );

  always #5 sensor_clk = ~sensor_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame phase, accepted pixels, running sums.
  int       m_phase, m_count, m_frames, m_sum, m_min, m_max;
  int       m_rd;
  bit       m_rd_known;
  bit       m_last_acc;
  int       mem   [N];
  bit       known [N];
  logic [7:0] pq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = P_IDLE;
    m_count    = 0;
    m_frames   = 0;
    m_sum      = 0;
    m_min      = 255;
    m_max      = 0;
    m_rd       = 0;
    m_rd_known = 1'b1;
    m_last_acc = 1'b0;
  endtask

  function automatic int exp_min();
`ifdef SINK_STATS_EN
    return m_min;
`else
    return 255;
`endif
  endfunction

  function automatic int exp_max();
`ifdef SINK_STATS_EN
    return m_max;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs(input string sfx);
    chk({"frame_done", sfx}, frame_done, m_phase == P_DONE);
    chk({"pix_count", sfx}, pix_count, m_count);
    chk({"checksum", sfx}, checksum, m_sum % 65536);
    chk({"frame_count", sfx}, frame_count, m_frames % 256);
    chk({"pix_min", sfx}, pix_min, exp_min());
    chk({"pix_max", sfx}, pix_max, exp_max());
    if (m_rd_known) chk({"rd_data", sfx}, rd_data, m_rd);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    bit acc;
    #1;
    chk("ready", ready, (m_phase == P_CAP) && !hold);
    @(posedge sensor_clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      acc        = (m_phase == P_CAP) && !hold && valid;
      m_last_acc = acc;
      m_rd_known = known[rd_addr];
      m_rd       = mem[rd_addr];
      if (acc) begin
        mem[m_count]   = pixel;
        known[m_count] = 1'b1;
        m_count++;
        m_sum += pixel;
        if (pixel < m_min) m_min = pixel;
        if (pixel > m_max) m_max = pixel;
      end
      case (m_phase)
        P_IDLE: if (enable) begin
          m_phase = P_CAP; m_count = 0; m_sum = 0; m_min = 255; m_max = 0;
        end
        P_CAP: begin
          if (acc && m_count == N) begin
            m_phase = P_DONE;
            m_frames++;
          end else if (!enable) begin
            m_phase = P_IDLE;
          end
        end
        default: if (frame_ack) m_phase = P_IDLE;
      endcase
    end
    @(negedge sensor_clk);
    check_outputs("");
  endtask

  // hold_mode: 0 none, 1 toggle each cycle, 2 random.
  task automatic run_until(input int target, input int budget, input int hold_mode);
    int c = 0;
    while (!(m_phase != P_IDLE && m_count == target) && c < budget) begin
      valid   = (pq.size() > 0);
      pixel   = valid ? pq[0] : 8'($urandom);
      hold    = (hold_mode == 1) ? (c % 2 == 1) : (hold_mode == 2) ? 1'($urandom) : 1'b0;
      rd_addr = AW'($urandom);
      tick();
      if (m_last_acc) void'(pq.pop_front());
      c++;
    end
    valid = 1'b0;
    hold  = 1'b0;
    chk("stream_within_budget", c < budget, 1);
  endtask

  task automatic ack_frame(input logic en);
    frame_ack = 1'b1;
    enable    = en;
    tick();
    frame_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin mem[i] = 0; known[i] = 1'b0; end
    model_reset();
    @(negedge sensor_clk);
    chk("rst_ready", ready, 0);
    check_outputs("_rst");
    tick();
    rst_n = 1'b1;

    // Frame 1: 0x01..0x10, no backpressure
    enable = 1'b1;
    for (int i = 0; i < N; i++) pq.push_back(8'(i + 1));
    run_until(N, 100, 0);
    chk("f1_done", frame_done, 1);
    chk("f1_count", pix_count, 16);
    chk("f1_sum", checksum, 16'h0088);
    chk("f1_frames", frame_count, 1);
    valid = 1'b1; pixel = 8'hAA; rd_addr = AW'(5);
    tick();
    chk("f1_ready_after_last", ready, 0);
    chk("f1_rd5", rd_data, 8'h06);
    valid = 1'b0;

    // Frame 2: same stream with hold toggling, then full readback
    ack_frame(1'b1);
    chk("gap_ready_low", ready, 0);
    for (int i = 0; i < N; i++) pq.push_back(8'(i + 1));
    run_until(N, 200, 1);
    chk("f2_sum", checksum, 16'h0088);
    chk("f2_frames", frame_count, 2);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      tick();
      chk("f2_readback", rd_data, i + 1);
    end

    // Frame 3: all 0xFF with random backpressure
    ack_frame(1'b1);
    for (int i = 0; i < N; i++) pq.push_back(8'hFF);
    run_until(N, 200, 2);
    chk("ff_sum", checksum, 16'h0FF0);

    // Abort after 7 accepts, then a fresh random frame
    ack_frame(1'b0);
    tick();
    enable = 1'b1;
    for (int i = 0; i < N; i++) pq.push_back(8'($urandom));
    run_until(7, 100, 2);
    enable = 1'b0;
    tick();
    chk("abort_count", pix_count, 7);
    chk("abort_done", frame_done, 0);
    chk("abort_frames", frame_count, 3);
    pq.delete();
    for (int i = 0; i < N; i++) pq.push_back(8'($urandom));
    enable = 1'b1;
    tick();
    chk("rearm_count", pix_count, 0);
    run_until(N, 200, 2);
    chk("rearm_frames", frame_count, 4);

    // DONE ignores a producer holding valid high
    valid = 1'b1; pixel = 8'h5A;
    for (int i = 0; i < 20; i++) begin rd_addr = AW'($urandom); tick(); end
    valid = 1'b0;
    chk("done_hold_frames", frame_count, 4);

    // Back-to-back frame after ack with enable held
    ack_frame(1'b1);
    for (int i = 0; i < N; i++) pq.push_back(8'($urandom));
    run_until(N, 200, 0);
    chk("b2b_frames", frame_count, 5);

    // Async reset mid-capture after 10 accepts
    ack_frame(1'b1);
    for (int i = 0; i < N; i++) pq.push_back(8'($urandom));
    run_until(10, 100, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ready", ready, 0);
    check_outputs("_arst");
    @(negedge sensor_clk);
    tick();
    rst_n = 1'b1;
    pq.delete();
    for (int i = 0; i < N; i++) pq.push_back(8'(8'h30 + i));
    run_until(N, 100, 0);
    chk("post_rst_frames", frame_count, 1);
    rd_addr = '0;
    tick();
    chk("post_rst_first_pixel", rd_data, 8'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_frame_sink.md
Name: pixel_frame_sink

Overview:
Receiving end of the sensor pixel stream. It accepts 8-bit pixels over the valid/ready handshake, where it drives ready, and stores one full frame of IMAGE_SIZE pixels into an internal buffer. While storing, it accumulates a 16-bit checksum. When the frame is complete it holds off the producer until software/downstream acknowledges it. Buffer contents can be read back through a registered read port for the processing stage.

Parameters:
IMAGE_SIZE, 1024, pixels per frame; buffer depth.
ADDR_W, $clog2(IMAGE_SIZE), buffer address width (derived; not overridden).

Ports:
sensor_clk  in  1  sole clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pixel  in  8  pixel data from producer
valid  in  1  pixel is valid
ready  out  1  sink can accept; transfer = valid && ready at a rising edge
enable  in  1  level; arms capture, dropping it aborts
hold  in  1  backpressure inject; forces ready low
frame_ack  in  1  single-cycle acknowledge of a completed frame
frame_done  out  1  level; complete frame held in buffer
pix_count  out  ADDR_W+1  pixels accepted in current/last frame
frame_count  out  8  completed frames, wraps 255->0
checksum  out  16  mod-2^16 sum of accepted pixels of current/last frame
rd_addr  in  ADDR_W  readback address
rd_data  out  8  buffer[rd_addr], 1-cycle latency
pix_min  out  8  see Optional Feature
pix_max  out  8  see Optional Feature

Behaviour:
- Reset (async assert, sync deassert by the sensor_clk edge): state=IDLE, ready=0, frame_done=0, pix_count=0, frame_count=0, checksum=0, rd_data=0, pix_min=8'hFF, pix_max=8'h00. Buffer contents are not cleared.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE -> CAPTURE when enable=1. On that edge, clear pix_count and checksum, and reset min/max.
- CAPTURE -> DONE on the edge accepting pixel index IMAGE_SIZE-1. That edge also increments frame_count.
- CAPTURE -> IDLE when enable=0 (abort). If a transfer occurs on the same edge, it is still accepted. pix_count and checksum are left holding partial values. frame_done stays 0.
- DONE -> IDLE on frame_ack=1. frame_ack outside DONE is ignored.
- ready = (state==CAPTURE) && !hold. It is combinational from the state register and hold only, never from valid.
- Because ready deasserts the cycle after the last accept, no pixel beyond IMAGE_SIZE is ever accepted.
- On each transfer:
  - buffer[pix_count] <= pixel
  - pix_count += 1
  - checksum <= checksum + {8'h00,pixel}, wrapping mod 2^16
- valid=1 with ready=0: nothing happens. The producer holds its data; the sink never drops it.
- frame_done = (state==DONE).
- pix_count reaches exactly IMAGE_SIZE at completion (hence width ADDR_W+1).
- Readback: rd_data <= buffer[rd_addr] every edge, in any state.
  - Read and write to the same address on the same edge returns old data.
  - rd_addr >= IMAGE_SIZE returns 8'h00.
- DONE with frame_ack and enable=1 on the same edge: goes to IDLE, then re-arms to CAPTURE on the next edge. There is a minimum one-cycle ready gap between frames.
- Reset mid-CAPTURE: outputs return to reset values immediately. The partial frame is lost.

Optional Feature:
Macro SINK_STATS_EN.
- Defined: pix_min/pix_max track the minimum/maximum accepted pixel of the current frame. They are reset to FF/00 on entering CAPTURE, updated on each transfer, and held in DONE/IDLE.
- Undefined: no compare logic; pix_min=8'hFF and pix_max=8'h00 constantly.
- Ports exist in both builds.

Test Plan:
- IMAGE_SIZE=16, enable=1, hold=0, pixels 0x01..0x10 streamed with valid=1 -> 16 accepts, frame_done=1, pix_count=16, checksum=0x0088, frame_count=1, ready=0 the cycle after the last accept; rd_addr=5 gives rd_data=0x06 one cycle later.
- Same stream with hold toggled 1/0 every other cycle -> only cycles with ready=1 accept; final buffer identical, checksum=0x0088, no duplicates or drops.
- 16 pixels of 0xFF -> checksum=0x0FF0. Next frame of 256-pixel build with all 0xFF -> checksum=0xFF00. With SINK_STATS_EN, min=max=0xFF.
- enable dropped after 7 accepts -> state IDLE, frame_done=0, pix_count=7, frame_count unchanged; re-enable -> pix_count cleared to 0, fresh frame completes normally.
- In DONE hold valid=1 for 20 cycles -> ready stays 0, no counter change. frame_ack with enable=1 -> one ready-low cycle, then ready=1 and second frame gives frame_count=2.
- rst_n pulsed low after 10 accepts -> all outputs at reset values asynchronously (before next edge); after release with enable=1, capture restarts at index 0.
